// File: rtl/tank_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tank_motion_ctrl
//   Controller for one player's tank. It decodes keyboard keycodes into drive,
//   rotate and fire commands. It integrates the tank position in fixed-point
//   sub-pixels, bounces the tank back off maze walls, and enforces a fire
//   cooldown. It also handles the hit/respawn sequence and the freeze at the
//   end of a round.
//
//   Ports
//     frame_clk    in   frame clock (only clock)
//     Reset_n      in   asynchronous active-low reset
//     keycode      in   KEY_SLOTS pressed-key bytes, 0 = empty slot
//     sin, cos     in   sign-magnitude heading vector (bit7 sign, 127 ~ 1.0)
//     isWall*      in   tank overlaps a wall on that side
//     hit          in   tank struck by a bullet this frame
//     game_end     in   nonzero = round over
//     spawn_x/y    in   respawn position, px
//     TankX/TankY  out  integer position, px
//     TankS        out  tank half-size
//     TankDX/DY    out  signed delta applied this frame, sub-pixel units
//     Angle        out  heading index, 0..ANGLE_STEPS-1
//     ShootBullet  out  one-frame fire pulse
//     Alive        out  1 unless in the DEAD state
// ---------------------------------------------------------------------------
module tank_motion_ctrl #(
    parameter int          KEY_SLOTS      = 4,
    parameter int          FRAC_BITS      = 3,
    parameter int          SPEED          = 16,
    parameter int          ANGLE_STEPS    = 45,
    parameter int          ANGLE_W        = 6,
    parameter int          TANK_SIZE      = 10,
    parameter int          X_CENTER       = 300,
    parameter int          Y_CENTER       = 250,
    parameter int          X_MIN          = 0,
    parameter int          X_MAX          = 639,
    parameter int          Y_MIN          = 0,
    parameter int          Y_MAX          = 479,
    parameter int          FIRE_COOLDOWN  = 30,
    parameter int          RESPAWN_FRAMES = 60,
    parameter logic [7:0]  KEY_FWD        = 8'h52,
    parameter logic [7:0]  KEY_BACK       = 8'h51,
    parameter logic [7:0]  KEY_CW         = 8'h50,
    parameter logic [7:0]  KEY_CCW        = 8'h4F,
    parameter logic [7:0]  KEY_FIRE       = 8'h2C
) (
    input  logic                     frame_clk,
    input  logic                     Reset_n,
    input  logic [8*KEY_SLOTS-1:0]   keycode,
    input  logic [7:0]               sin,
    input  logic [7:0]               cos,
    input  logic                     isWallTop,
    input  logic                     isWallBottom,
    input  logic                     isWallLeft,
    input  logic                     isWallRight,
    input  logic                     hit,
    input  logic [1:0]               game_end,
    input  logic [9:0]               spawn_x,
    input  logic [9:0]               spawn_y,
    output logic [9:0]               TankX,
    output logic [9:0]               TankY,
    output logic [9:0]               TankS,
    output logic [9:0]               TankDX,
    output logic [9:0]               TankDY,
    output logic [ANGLE_W-1:0]       Angle,
    output logic                     ShootBullet,
    output logic                     Alive
);

    localparam int POS_W = 10 + FRAC_BITS;
    localparam int SUM_W = POS_W + 2;
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 1);
    localparam int TMR_W = $clog2(RESPAWN_FRAMES + 1);
    localparam int X_LO  = X_MIN + TANK_SIZE;
    localparam int X_HI  = X_MAX - TANK_SIZE;
    localparam int Y_LO  = Y_MIN + TANK_SIZE;
    localparam int Y_HI  = Y_MAX - TANK_SIZE;

    localparam logic [POS_W-1:0] X_HOME  = {10'(X_CENTER), {FRAC_BITS{1'b0}}};
    localparam logic [POS_W-1:0] Y_HOME  = {10'(Y_CENTER), {FRAC_BITS{1'b0}}};
    localparam logic [6:0]       SPEED_7 = 7'(SPEED);

    typedef enum logic [1:0] {ST_ALIVE, ST_DEAD, ST_FROZEN} state_t;

    state_t             state_q,     state_d;
    logic [POS_W-1:0]   pos_x_q,     pos_x_d;
    logic [POS_W-1:0]   pos_y_q,     pos_y_d;
    logic [9:0]         dx_q,        dx_d;
    logic [9:0]         dy_q,        dy_d;
    logic [ANGLE_W-1:0] angle_q,     angle_d;
    logic               shoot_q,     shoot_d;
    logic [CD_W-1:0]    cooldown_q,  cooldown_d;
    logic               fire_prev_q, fire_prev_d;
    logic [TMR_W-1:0]   timer_q,     timer_d;

    // ---------------- key decode: a key counts if any slot holds its code
    logic [KEY_SLOTS-1:0] fwd_m, back_m, cw_m, ccw_m, fire_m;

    for (genvar gi = 0; gi < KEY_SLOTS; gi++) begin : g_slot
        assign fwd_m[gi]  = (keycode[8*gi +: 8] == KEY_FWD);
        assign back_m[gi] = (keycode[8*gi +: 8] == KEY_BACK);
        assign cw_m[gi]   = (keycode[8*gi +: 8] == KEY_CW);
        assign ccw_m[gi]  = (keycode[8*gi +: 8] == KEY_CCW);
        assign fire_m[gi] = (keycode[8*gi +: 8] == KEY_FIRE);
    end

    logic key_fwd, key_back, key_cw, key_ccw, key_fire, wall;
    assign key_fwd  = |fwd_m;
    assign key_back = |back_m;
    assign key_cw   = |cw_m;
    assign key_ccw  = |ccw_m;
    assign key_fire = |fire_m;
    assign wall     = isWallTop | isWallBottom | isWallLeft | isWallRight;

    // ---------------- per-frame step: SPEED * magnitude / 128, sign re-applied
    logic [13:0] dx_prod, dy_prod;
    logic [9:0]  dx_mag, dy_mag, dx_step, dy_step;

    assign dx_prod = 14'(cos[6:0]) * 14'(SPEED_7);
    assign dy_prod = 14'(sin[6:0]) * 14'(SPEED_7);
    assign dx_mag  = {3'b000, dx_prod[13:7]};
    assign dy_mag  = {3'b000, dy_prod[13:7]};
    assign dx_step = cos[7] ? (10'd0 - dx_mag) : dx_mag;
    assign dy_step = sin[7] ? (10'd0 - dy_mag) : dy_mag;

    // Add a signed delta to a position. The sum is widened so an underflow
    // below zero is seen as negative and clamps to the low limit. On a clamp
    // the fraction is dropped.
    function automatic logic [POS_W-1:0] move_clamp(input logic [POS_W-1:0] pos,
                                                    input logic [9:0]       delta,
                                                    input int               lo,
                                                    input int               hi);
        logic signed [SUM_W-1:0] sum;
        logic signed [SUM_W-1:0] ipart;
        sum   = $signed({2'b00, pos}) + $signed({{(SUM_W-10){delta[9]}}, delta});
        ipart = sum >>> FRAC_BITS;
        if (ipart < $signed(SUM_W'(lo))) begin
            move_clamp = {10'(lo), {FRAC_BITS{1'b0}}};
        end else if (ipart > $signed(SUM_W'(hi))) begin
            move_clamp = {10'(hi), {FRAC_BITS{1'b0}}};
        end else begin
            move_clamp = sum[POS_W-1:0];
        end
    endfunction

    // ---------------- next-state logic
    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        angle_d     = angle_q;
        shoot_d     = 1'b0;
        cooldown_d  = (cooldown_q != '0) ? cooldown_q - 1'b1 : '0;
        fire_prev_d = key_fire;
        timer_d     = timer_q;

        case (state_q)
            ST_ALIVE: begin
                if (game_end != 2'd0) begin
                    state_d    = ST_FROZEN;
                    pos_x_d    = X_HOME;
                    pos_y_d    = Y_HOME;
                    angle_d    = '0;
                    dx_d       = '0;
                    dy_d       = '0;
                    cooldown_d = '0;
                end else if (hit) begin
                    state_d = ST_DEAD;
                    timer_d = TMR_W'(RESPAWN_FRAMES - 1);
                    dx_d    = '0;
                    dy_d    = '0;
                end else begin
                    // Rising edge of fire only, and only once the cooldown is spent.
                    if (key_fire && !fire_prev_q && cooldown_q == '0) begin
                        shoot_d    = 1'b1;
                        cooldown_d = CD_W'(FIRE_COOLDOWN);
                    end
                    if (wall) begin
                        // Undo last frame's move. Drive and rotate are locked out.
                        pos_x_d = move_clamp(pos_x_q, 10'd0 - dx_q, X_LO, X_HI);
                        pos_y_d = move_clamp(pos_y_q, 10'd0 - dy_q, Y_LO, Y_HI);
                        dx_d    = '0;
                        dy_d    = '0;
                    end else if (key_fwd) begin
                        // Screen y grows downward, so forward subtracts sin.
                        pos_x_d = move_clamp(pos_x_q, dx_step, X_LO, X_HI);
                        pos_y_d = move_clamp(pos_y_q, 10'd0 - dy_step, Y_LO, Y_HI);
                        dx_d    = dx_step;
                        dy_d    = 10'd0 - dy_step;
                    end else if (key_back) begin
                        pos_x_d = move_clamp(pos_x_q, 10'd0 - dx_step, X_LO, X_HI);
                        pos_y_d = move_clamp(pos_y_q, dy_step, Y_LO, Y_HI);
                        dx_d    = 10'd0 - dx_step;
                        dy_d    = dy_step;
                    end else begin
                        dx_d = '0;
                        dy_d = '0;
                        if (key_cw) begin
                            angle_d = (angle_q == ANGLE_W'(ANGLE_STEPS - 1)) ? '0 : angle_q + 1'b1;
                        end else if (key_ccw) begin
                            angle_d = (angle_q == '0) ? ANGLE_W'(ANGLE_STEPS - 1) : angle_q - 1'b1;
                        end
                    end
                end
            end

            ST_DEAD: begin
                dx_d = '0;
                dy_d = '0;
                if (game_end != 2'd0) begin
                    state_d    = ST_FROZEN;
                    pos_x_d    = X_HOME;
                    pos_y_d    = Y_HOME;
                    angle_d    = '0;
                    cooldown_d = '0;
                end else if (timer_q == '0) begin
                    state_d    = ST_ALIVE;
                    pos_x_d    = {spawn_x, {FRAC_BITS{1'b0}}};
                    pos_y_d    = {spawn_y, {FRAC_BITS{1'b0}}};
                    angle_d    = '0;
                    cooldown_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end

            default: begin // ST_FROZEN
                pos_x_d    = X_HOME;
                pos_y_d    = Y_HOME;
                angle_d    = '0;
                dx_d       = '0;
                dy_d       = '0;
                cooldown_d = '0;
                if (game_end == 2'd0) begin
                    state_d = ST_ALIVE;
                end
            end
        endcase
    end

    // ---------------- state registers
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_ALIVE;
            pos_x_q     <= X_HOME;
            pos_y_q     <= Y_HOME;
            dx_q        <= '0;
            dy_q        <= '0;
            angle_q     <= '0;
            shoot_q     <= 1'b0;
            cooldown_q  <= '0;
            fire_prev_q <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            angle_q     <= angle_d;
            shoot_q     <= shoot_d;
            cooldown_q  <= cooldown_d;
            fire_prev_q <= fire_prev_d;
            timer_q     <= timer_d;
        end
    end

    assign TankX       = pos_x_q[FRAC_BITS +: 10];
    assign TankY       = pos_y_q[FRAC_BITS +: 10];
    assign TankS       = 10'(TANK_SIZE);
    assign TankDX      = dx_q;
    assign TankDY      = dy_q;
    assign Angle       = angle_q;
    assign ShootBullet = shoot_q;
    assign Alive       = (state_q != ST_DEAD);

endmodule

// File: tb/tb_tank_motion_ctrl.sv
module tb_tank_motion_ctrl;

    logic        frame_clk;
    logic        Reset_n;
    logic [31:0] keycode;
    logic [7:0]  sin, cos;
    logic        isWallTop, isWallBottom, isWallLeft, isWallRight;
    logic        hit;
    logic [1:0]  game_end;
    logic [9:0]  spawn_x, spawn_y;
    logic [9:0]  TankX, TankY, TankS, TankDX, TankDY;
    logic [5:0]  Angle;
    logic        ShootBullet, Alive;

    tank_motion_ctrl dut (
        .frame_clk   (frame_clk),
        .Reset_n     (Reset_n),
        .keycode     (keycode),
        .sin         (sin),
        .cos         (cos),
        .isWallTop   (isWallTop),
        .isWallBottom(isWallBottom),
        .isWallLeft  (isWallLeft),
        .isWallRight (isWallRight),
        .hit         (hit),
        .game_end    (game_end),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .TankX       (TankX),
        .TankY       (TankY),
        .TankS       (TankS),
        .TankDX      (TankDX),
        .TankDY      (TankDY),
        .Angle       (Angle),
        .ShootBullet (ShootBullet),
        .Alive       (Alive)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int frame_no = 0;

    // Reference model. Positions are whole sub-pixel counts, 8 per pixel.
    // The state codes are 0 = alive, 1 = dead, 2 = frozen.
    int m_state, m_x, m_y, m_dx, m_dy, m_ang, m_cd, m_fp, m_shoot, m_timer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clamp_sub(input int v, input int lo, input int hi);
        int ip;
        ip = (v >= 0) ? v / 8 : -((-v + 7) / 8);
        if (ip < lo) return lo * 8;
        if (ip > hi) return hi * 8;
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_x = 300 * 8; m_y = 250 * 8; m_dx = 0; m_dy = 0;
        m_ang = 0; m_cd = 0; m_fp = 0; m_shoot = 0; m_timer = 0;
    endtask

    task automatic model_step();
        bit kf, kb, kcw, kccw, kfire;
        int dxs, dys, cd_next;
        logic [7:0] code;
        kf = 0; kb = 0; kcw = 0; kccw = 0; kfire = 0;
        for (int s = 0; s < 4; s++) begin
            code = keycode[8*s +: 8];
            if (code == 8'h52) kf = 1;
            if (code == 8'h51) kb = 1;
            if (code == 8'h50) kcw = 1;
            if (code == 8'h4F) kccw = 1;
            if (code == 8'h2C) kfire = 1;
        end
        dxs = (16 * int'(cos[6:0])) / 128; if (cos[7]) dxs = -dxs;
        dys = (16 * int'(sin[6:0])) / 128; if (sin[7]) dys = -dys;
        cd_next = (m_cd > 0) ? m_cd - 1 : 0;
        m_shoot = 0;
        if (m_state == 0) begin
            if (game_end != 0) begin
                m_state = 2; m_x = 2400; m_y = 2000; m_ang = 0; m_dx = 0; m_dy = 0; cd_next = 0;
            end else if (hit) begin
                m_state = 1; m_timer = 59; m_dx = 0; m_dy = 0;
            end else begin
                if (kfire && !m_fp && m_cd == 0) begin
                    m_shoot = 1; cd_next = 30;
                end
                if (isWallTop || isWallBottom || isWallLeft || isWallRight) begin
                    m_x = clamp_sub(m_x - m_dx, 10, 629);
                    m_y = clamp_sub(m_y - m_dy, 10, 469);
                    m_dx = 0; m_dy = 0;
                end else if (kf) begin
                    m_x = clamp_sub(m_x + dxs, 10, 629);
                    m_y = clamp_sub(m_y - dys, 10, 469);
                    m_dx = dxs; m_dy = -dys;
                end else if (kb) begin
                    m_x = clamp_sub(m_x - dxs, 10, 629);
                    m_y = clamp_sub(m_y + dys, 10, 469);
                    m_dx = -dxs; m_dy = dys;
                end else begin
                    m_dx = 0; m_dy = 0;
                    if (kcw) m_ang = (m_ang + 1) % 45;
                    else if (kccw) m_ang = (m_ang + 44) % 45;
                end
            end
        end else if (m_state == 1) begin
            m_dx = 0; m_dy = 0;
            if (game_end != 0) begin
                m_state = 2; m_x = 2400; m_y = 2000; m_ang = 0; cd_next = 0;
            end else if (m_timer == 0) begin
                m_state = 0; m_x = int'(spawn_x) * 8; m_y = int'(spawn_y) * 8; m_ang = 0; cd_next = 0;
            end else begin
                m_timer--;
            end
        end else begin
            m_x = 2400; m_y = 2000; m_ang = 0; m_dx = 0; m_dy = 0; cd_next = 0;
            if (game_end == 0) m_state = 0;
        end
        m_cd = cd_next;
        m_fp = kfire;
    endtask

    task automatic check_all();
        check("TankX",  {22'd0, TankX},  32'(m_x / 8));
        check("TankY",  {22'd0, TankY},  32'(m_y / 8));
        check("TankDX", {22'd0, TankDX}, 32'(m_dx) & 32'h3FF);
        check("TankDY", {22'd0, TankDY}, 32'(m_dy) & 32'h3FF);
        check("Angle",  {26'd0, Angle},  32'(m_ang));
        check("Shoot",  {31'd0, ShootBullet}, 32'(m_shoot));
        check("Alive",  {31'd0, Alive},  (m_state != 1) ? 32'd1 : 32'd0);
        check("TankS",  {22'd0, TankS},  32'd10);
    endtask

    // One frame: model sees the same inputs the DUT samples on this edge.
    task automatic step();
        model_step();
        @(posedge frame_clk);
        #1;
        frame_no++;
        $display("[TB] frame %0d key=%h x=%0d y=%0d dx=%0d dy=%0d ang=%0d shot=%0d alive=%0d",
                 frame_no, keycode, TankX, TankY, $signed(TankDX), $signed(TankDY),
                 Angle, ShootBullet, Alive);
        check_all();
    endtask

    task automatic clear_inputs();
        keycode = '0; sin = 8'h00; cos = 8'h00;
        isWallTop = 0; isWallBottom = 0; isWallLeft = 0; isWallRight = 0;
        hit = 0; game_end = 2'd0;
    endtask

    initial begin
        int ge_left;
        logic [7:0] kb;
        Reset_n = 1'b0;
        clear_inputs();
        spawn_x = 10'd100; spawn_y = 10'd200;
        model_reset();

        // 1. reset values
        repeat (2) @(posedge frame_clk);
        #1;
        check("rst_x", {22'd0, TankX}, 32'd300);
        check("rst_y", {22'd0, TankY}, 32'd250);
        check("rst_ang", {26'd0, Angle}, 32'd0);
        check("rst_shoot", {31'd0, ShootBullet}, 32'd0);
        check("rst_alive", {31'd0, Alive}, 32'd1);
        check("rst_dx", {22'd0, TankDX}, 32'd0);
        check("rst_dy", {22'd0, TankDY}, 32'd0);
        Reset_n = 1'b1;

        // 2. forward 8 frames along +x
        cos = 8'h7F; sin = 8'h00; keycode = 32'h0000_0052;
        for (int f = 0; f < 8; f++) begin
            step();
            check("fwd_dx", {22'd0, TankDX}, 32'd15);
        end
        check("fwd_x8", {22'd0, TankX}, 32'd315);
        check("fwd_y8", {22'd0, TankY}, 32'd250);

        // 3. rotation wrap, keys in slot 0 and slot 3
        keycode = 32'h0000_004F; step();
        check("ccw_wrap", {26'd0, Angle}, 32'd44);
        keycode = 32'h5000_0000; step();
        check("cw_wrap", {26'd0, Angle}, 32'd0);
        step();
        check("cw_one", {26'd0, Angle}, 32'd1);

        // 4. fire edge detection and cooldown
        for (int f = 1; f <= 32; f++) begin
            keycode = (f <= 5 || f == 10 || f == 32) ? 32'h0000_002C : 32'h0;
            step();
            check("fire_pulse", {31'd0, ShootBullet}, (f == 1 || f == 32) ? 32'd1 : 32'd0);
        end

        // 5. wall bounce-back
        keycode = 32'h0000_0052; step();
        check("pre_wall_dx", {22'd0, TankDX}, 32'd15);
        check("pre_wall_x", {22'd0, TankX}, 32'd316);
        keycode = 32'h0000_0050; isWallRight = 1; step();
        check("wall_x", {22'd0, TankX}, 32'd315);
        check("wall_dx", {22'd0, TankDX}, 32'd0);
        check("wall_ang", {26'd0, Angle}, 32'd1);
        isWallRight = 0; keycode = 32'h0;

        // 6. hit, respawn, then freeze while dead
        spawn_x = 10'd100; spawn_y = 10'd200;
        hit = 1; keycode = 32'h0000_2C52;
        step();
        hit = 0;
        check("dead_alive", {31'd0, Alive}, 32'd0);
        for (int f = 2; f <= 60; f++) begin
            step();
            check("dead_hold", {31'd0, Alive}, 32'd0);
        end
        step();
        check("respawn_alive", {31'd0, Alive}, 32'd1);
        check("respawn_x", {22'd0, TankX}, 32'd100);
        check("respawn_y", {22'd0, TankY}, 32'd200);
        check("respawn_ang", {26'd0, Angle}, 32'd0);
        keycode = 32'h0;
        hit = 1; step(); hit = 0;
        repeat (20) step();
        game_end = 2'd1; step();
        check("frozen_x", {22'd0, TankX}, 32'd300);
        check("frozen_y", {22'd0, TankY}, 32'd250);
        check("frozen_alive", {31'd0, Alive}, 32'd1);
        step();
        game_end = 2'd0; step();
        step();

        // 7. randomized frames against the model
        ge_left = 0;
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < 4; s++) begin
                case ($urandom_range(0, 11))
                    0: kb = 8'h52;
                    1: kb = 8'h51;
                    2: kb = 8'h50;
                    3: kb = 8'h4F;
                    4: kb = 8'h2C;
                    5: kb = 8'h1A;
                    default: kb = 8'h00;
                endcase
                keycode[8*s +: 8] = kb;
            end
            sin = 8'($urandom); cos = 8'($urandom);
            isWallTop    = ($urandom_range(0, 15) == 0);
            isWallBottom = ($urandom_range(0, 15) == 0);
            isWallLeft   = ($urandom_range(0, 15) == 0);
            isWallRight  = ($urandom_range(0, 15) == 0);
            hit = ($urandom_range(0, 49) == 0);
            if (ge_left > 0) ge_left--;
            else if ($urandom_range(0, 99) == 0) ge_left = $urandom_range(1, 4);
            game_end = (ge_left > 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            spawn_x = 10'($urandom_range(10, 629));
            spawn_y = 10'($urandom_range(10, 469));
            step();
        end

        // 8. asynchronous reset mid-operation
        Reset_n = 1'b0;
        #2;
        model_reset();
        check("arst_x", {22'd0, TankX}, 32'd300);
        check("arst_y", {22'd0, TankY}, 32'd250);
        check("arst_ang", {26'd0, Angle}, 32'd0);
        check("arst_alive", {31'd0, Alive}, 32'd1);
        check("arst_shoot", {31'd0, ShootBullet}, 32'd0);
        Reset_n = 1'b1;
        clear_inputs();
        keycode = 32'h0000_002C;
        step();
        check("post_rst_fire", {31'd0, ShootBullet}, 32'd1);
        keycode = 32'h0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
